hazard_forward_unit: RTL

Parametrised hazard and forwarding controller for the five-stage RISC-V pipeline. It generates per-operand forwarding selects for the EX stage, detects load-use and multi-cycle-unit RAW and structural hazards at ID, and drives stall/bubble controls. It tracks one outstanding multi-cycle operation (divider class) with an internal FSM and latency counter, and it keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_forward_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard detection, EX-stage operand forwarding and multi-cycle op tracking.
// Also keeps a saturating count of stalled cycles.
module hazard_forward_unit #(
  parameter int NUM_RS = 2,
  parameter int REG_AW = 5,
  parameter int MC_LAT = 34,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RS*REG_AW-1:0] rs_ID_EX_in,
  input  logic [NUM_RS*REG_AW-1:0] rs_IF_ID_in,
  input  logic [NUM_RS-1:0]        rs_used_IF_ID_in,
  input  logic                     mc_req_IF_ID_in,
  input  logic [REG_AW-1:0]        rd_ID_EX_in,
  input  logic                     MemRead_ID_EX_in,
  input  logic [REG_AW-1:0]        rd_EX_MEM_in,
  input  logic                     RegWrite_EX_MEM_in,
  input  logic [REG_AW-1:0]        rd_MEM_WB_in,
  input  logic                     RegWrite_MEM_WB_in,
  input  logic                     mc_start_in,
  input  logic [REG_AW-1:0]        mc_rd_in,
  output logic [2*NUM_RS-1:0]      forward_out,
  output logic                     stall_out,
  output logic                     bubble_out,
  output logic                     mc_busy_out,
  output logic                     mc_done_out,
  output logic [CNT_W-1:0]         stall_cnt_out
);

  localparam int CW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(MC_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [REG_AW-1:0] mc_rd_q, mc_rd_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic lu_hit, raw_hit;
  logic load_use, mc_raw, structural, hazard;

  // Per-operand forward select; MEM result wins over WB, x0 never forwarded.
  always_comb begin
    forward_out = '0;
    if (!rst) begin
      for (int i = 0; i < NUM_RS; i++) begin
        if (RegWrite_EX_MEM_in && rd_EX_MEM_in != '0 &&
            rd_EX_MEM_in == rs_ID_EX_in[i*REG_AW +: REG_AW])
          forward_out[2*i +: 2] = 2'b10;
        else if (RegWrite_MEM_WB_in && rd_MEM_WB_in != '0 &&
                 rd_MEM_WB_in == rs_ID_EX_in[i*REG_AW +: REG_AW])
          forward_out[2*i +: 2] = 2'b01;
      end
    end
  end

  // Match used ID sources against the load and multi-cycle destinations.
  always_comb begin
    lu_hit  = 1'b0;
    raw_hit = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (rs_used_IF_ID_in[i] &&
          rs_IF_ID_in[i*REG_AW +: REG_AW] == rd_ID_EX_in)
        lu_hit = 1'b1;
      if (rs_used_IF_ID_in[i] &&
          rs_IF_ID_in[i*REG_AW +: REG_AW] == mc_rd_q)
        raw_hit = 1'b1;
    end
  end

  assign load_use   = MemRead_ID_EX_in && rd_ID_EX_in != '0 && lu_hit;
  assign mc_raw     = (state_q == BUSY || state_q == DONE) &&
                      mc_rd_q != '0 && raw_hit;
  assign structural = mc_req_IF_ID_in &&
                      (state_q == BUSY || mc_start_in);
  assign hazard     = !rst && (load_use || mc_raw || structural);

  assign stall_out     = hazard;
  assign bubble_out    = hazard;
  assign mc_busy_out   = state_q != IDLE;
  assign mc_done_out   = state_q == DONE;
  assign stall_cnt_out = stall_cnt_q;

  // Multi-cycle op tracker: next state, latency count and destination.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_rd_d = mc_rd_q;
    unique case (state_q)
      IDLE: begin
        if (mc_start_in) begin
          state_d = BUSY;
          cnt_d   = LOAD;
          mc_rd_d = mc_rd_in;
        end
      end
      BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else             state_d = DONE;
      end
      DONE: begin
        if (mc_start_in) begin
          state_d = BUSY;
          cnt_d   = LOAD;
          mc_rd_d = mc_rd_in;
        end else begin
          state_d = IDLE;
          mc_rd_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        mc_rd_d = '0;
      end
    endcase
  end

  // Stall counter sticks at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mc_rd_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mc_rd_q     <= mc_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
